// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the CPU control path:
//   - opcode constants (also used by the ALU)
//   - phase_e: the eight instruction phases, INST_ADDR..STORE
//   - is_alu_op(): true for opcodes whose operand is read from memory
//     and whose result lands in the accumulator (ADD, AND, XOR, LDA)
package cpu_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] OP_HLT = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_AND = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_LDA = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_STO = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if
// Bundles the controller's datapath-facing signals.
//   opcode, zero          : from IR / ALU into the controller
//   sel, rd, ld_ir, inc_pc,
//   ld_pc, ld_ac, wr,
//   data_e, halt          : control strobes out of the controller
//   phase                 : current phase, exported for debug / checkers
// Modports:
//   master : the controller (drives control strobes, reads opcode/zero)
//   slave  : the datapath side (drives opcode/zero, reads strobes)
// All signals are level-sensitive and sampled on the rising clock edge;
// there is no valid/ready handshake, every strobe is meaningful in the
// cycle it is asserted.
interface cpu_controller_if;
    import cpu_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                sel;
    logic                rd;
    logic                ld_ir;
    logic                inc_pc;
    logic                ld_pc;
    logic                ld_ac;
    logic                wr;
    logic                data_e;
    logic                halt;
    logic [2:0]          phase;

    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

endinterface

// File: rtl/cpu_phase_counter.sv
// cpu_phase_counter
// Holds the 3-bit phase register and the halted flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : (only with CPU_CTRL_STEP_EN) phase IDLE holds until step=1
//   opcode     : current instruction opcode (only HLT matters here)
//   phase      : current phase
//   halted     : set at the end of OP_ADDR for HLT, cleared only by reset
// Optional feature macro: CPU_CTRL_STEP_EN (single-step gating at IDLE).
module cpu_phase_counter
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
`ifdef CPU_CTRL_STEP_EN
    input  logic                step,
`endif
    input  logic [OPCODE_W-1:0] opcode,
    output phase_e              phase,
    output logic                halted
);

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next-state: once halted, phase stays frozen at OP_ADDR.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
`ifdef CPU_CTRL_STEP_EN
            else if (phase_q == IDLE && !step) begin
                phase_d = phase_q;
            end
`endif
            else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    // Outputs
    always_comb begin
        phase  = phase_q;
        halted = halted_q;
    end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller
// Control unit of the 8-phase accumulator CPU. All control strobes are
// combinational decodes of phase, opcode, zero and the halted flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : (only with CPU_CTRL_STEP_EN) release phase IDLE
//   bus        : cpu_controller_if.master (opcode/zero in, strobes out)
// Optional feature macro: CPU_CTRL_STEP_EN.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef CPU_CTRL_STEP_EN
    input  logic              step,
`endif
    cpu_controller_if.master  bus
);

    phase_e phase;
    logic   halted;
    logic   alu_op;

    cpu_phase_counter u_phase_counter (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef CPU_CTRL_STEP_EN
        .step   (step),
`endif
        .opcode (bus.opcode),
        .phase  (phase),
        .halted (halted)
    );

    assign alu_op    = is_alu_op(bus.opcode);
    assign bus.phase = phase;

    // Output decode. Phases 0-3 ignore opcode, so an IR that is still
    // being loaded cannot disturb the fetch strobes. zero is only looked
    // at in ALU_OP for SKZ.
    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        bus.data_e = 1'b0;
        bus.halt   = 1'b0;
        if (halted) begin
            bus.halt = 1'b1;
        end else begin
            unique case (phase)
                INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = (bus.opcode == OP_HLT);
                end
                OP_FETCH: begin
                    bus.rd = alu_op;
                end
                ALU_OP: begin
                    bus.rd     = alu_op;
                    bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
                    bus.ld_pc  = (bus.opcode == OP_JMP);
                    bus.data_e = (bus.opcode == OP_STO);
                end
                STORE: begin
                    bus.rd     = alu_op;
                    bus.ld_ac  = alu_op;
                    bus.ld_pc  = (bus.opcode == OP_JMP);
                    bus.wr     = (bus.opcode == OP_STO);
                    bus.data_e = (bus.opcode == OP_STO);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller
// Directed test of cpu_controller. Control strobes are compared as a
// 9-bit vector {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
// against hand-written per-phase tables.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
`ifdef CPU_CTRL_STEP_EN
    logic step;
`endif

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef CPU_CTRL_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] ctrl;
    assign ctrl = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                   bus.ld_ac, bus.wr, bus.data_e, bus.halt};

    localparam logic [8:0] C_IDLE   = 9'b000000000;
    localparam logic [8:0] C_P0     = 9'b100000000;
    localparam logic [8:0] C_P1     = 9'b110000000;
    localparam logic [8:0] C_P2     = 9'b111000000;
    localparam logic [8:0] C_P3     = 9'b111000000;
    localparam logic [8:0] C_INCPC  = 9'b000100000;
    localparam logic [8:0] C_HALTED = 9'b000000001;

    // Phase 0 in the MSBs, phase 7 in the LSBs.
    localparam logic [71:0] EXP_ALU  = {C_P0, C_P1, C_P2, C_P3, C_INCPC,
                                        9'b010000000, 9'b010000000, 9'b010001000};
    localparam logic [71:0] EXP_STO  = {C_P0, C_P1, C_P2, C_P3, C_INCPC,
                                        C_IDLE, 9'b000000010, 9'b000000110};
    localparam logic [71:0] EXP_SKZ1 = {C_P0, C_P1, C_P2, C_P3, C_INCPC,
                                        C_IDLE, C_INCPC, C_IDLE};
    localparam logic [71:0] EXP_SKZ0 = {C_P0, C_P1, C_P2, C_P3, C_INCPC,
                                        C_IDLE, C_IDLE, C_IDLE};
    localparam logic [71:0] EXP_JMP  = {C_P0, C_P1, C_P2, C_P3, C_INCPC,
                                        C_IDLE, 9'b000010000, 9'b000010000};
    localparam logic [71:0] EXP_HLT  = {C_P0, C_P1, C_P2, C_P3, 9'b000100001,
                                        C_IDLE, C_IDLE, C_IDLE};

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Entered between edges with phase expected at 0. Walks n phases;
    // phases 0-2 get a random opcode to show the fetch decode ignores it.
    // Returns 1 ns after the edge that ends phase n-1.
    task automatic run_phases(input logic [2:0] op, input logic z,
                              input logic [71:0] exp_v, input int n,
                              input string tag);
        for (int p = 0; p < n; p++) begin
            bus.opcode = (p < 3) ? 3'($urandom_range(0, 7)) : op;
            bus.zero   = (p == 6) ? z : 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("%s phase p%0d", tag, p), {6'd0, bus.phase}, 9'(p));
            chk($sformatf("%s ctrl p%0d", tag, p), ctrl, exp_v[(7-p)*9 +: 9]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.opcode = OP_ADD;
        bus.zero   = 1'b0;
`ifdef CPU_CTRL_STEP_EN
        step       = 1'b1;
`endif
        // Reset state, before and after clock edges
        #1;
        chk("reset phase", {6'd0, bus.phase}, 9'd0);
        chk("reset ctrl", ctrl, C_P0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset held phase", {6'd0, bus.phase}, 9'd0);
        chk("reset held ctrl", ctrl, C_P0);
        rst_n = 1'b1;

        // Full instructions
        run_phases(OP_ADD, 1'b0, EXP_ALU,  8, "ADD");
        run_phases(OP_AND, 1'b1, EXP_ALU,  8, "AND");
        run_phases(OP_XOR, 1'b0, EXP_ALU,  8, "XOR");
        run_phases(OP_LDA, 1'b1, EXP_ALU,  8, "LDA");
        run_phases(OP_STO, 1'b1, EXP_STO,  8, "STO");
        run_phases(OP_SKZ, 1'b1, EXP_SKZ1, 8, "SKZ z1");
        run_phases(OP_SKZ, 1'b0, EXP_SKZ0, 8, "SKZ z0");
        run_phases(OP_JMP, 1'b1, EXP_JMP,  8, "JMP");
        chk("wrap phase", {6'd0, bus.phase}, 9'd0);

        // HLT: halt from phase 4, then frozen for 20 cycles
        run_phases(OP_HLT, 1'b0, EXP_HLT, 5, "HLT");
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 3'($urandom_range(0, 7));
            bus.zero   = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("halted phase c%0d", i), {6'd0, bus.phase}, 9'd4);
            chk($sformatf("halted ctrl c%0d", i), ctrl, C_HALTED);
            @(posedge clk);
            #1;
        end

        // 3 ns reset pulse between edges leaves halt at once
        #2;
        rst_n = 1'b0;
        #1;
        chk("halt reset phase", {6'd0, bus.phase}, 9'd0);
        chk("halt reset ctrl", ctrl, C_P0);
        #2;
        rst_n = 1'b1;
        run_phases(OP_ADD, 1'b0, EXP_ALU, 8, "ADD after halt");

        // Reset in ALU_OP of STO: no wr / ld_* afterwards
        run_phases(OP_STO, 1'b0, EXP_STO, 6, "STO abort");
        bus.opcode = OP_STO;
        chk("STO abort p6 ctrl", ctrl, 9'b000000010);
        rst_n = 1'b0;
        #1;
        chk("STO abort reset ctrl", ctrl, C_P0);
        @(posedge clk);
        #1;
        chk("STO abort held phase", {6'd0, bus.phase}, 9'd0);
        chk("STO abort held ctrl", ctrl, C_P0);
        rst_n = 1'b1;
        run_phases(OP_JMP, 1'b0, EXP_JMP, 8, "JMP after abort");

`ifdef CPU_CTRL_STEP_EN
        // Single-step gating at IDLE
        run_phases(OP_ADD, 1'b0, EXP_ALU, 3, "STEP");
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("step hold phase c%0d", i), {6'd0, bus.phase}, 9'd3);
            chk($sformatf("step hold ctrl c%0d", i), ctrl, C_P3);
            @(posedge clk);
            #1;
        end
        step = 1'b1;
        @(posedge clk);
        #1;
        chk("step release phase", {6'd0, bus.phase}, 9'd4);
        chk("step release ctrl", ctrl, C_INCPC);
        repeat (4) @(posedge clk);
        #1;
        chk("step wrap phase", {6'd0, bus.phase}, 9'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
